// File: rtl/inst_axi_bridge_pkg.sv
// Shared AXI and sram-like encodings for the instruction fetch bridge.
package inst_axi_bridge_pkg;
  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;
  localparam logic [7:0] ARLEN_SINGLE   = 8'd0;
endpackage

// File: rtl/inst_axi_bridge.sv
// Fetch-side sram-like read requests turned into single-beat, in-order AXI3 reads.
module inst_axi_bridge
  import inst_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID  = 4'd0,
  parameter int         MAX_OUT = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);

  logic       accept;
  logic       r_fire;
  logic [1:0] out_cnt;
  logic       unused_inputs;

  // Write data, ids and rlast carry no information for in-order single-beat reads.
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast, 1'b0};

  // Accept is masked during reset so a held request is never acknowledged.
  assign accept = aresetn & inst_sram_req & ~inst_sram_wr & ~arvalid & (out_cnt < MAX_CNT);
  assign r_fire = rvalid & rready;

  assign inst_sram_addr_ok = accept;
  assign inst_sram_data_ok = r_fire;
  assign inst_sram_rdata   = rdata;
  assign rready            = (out_cnt != 2'd0);

  assign arid    = AXI_ID;
  assign arlen   = ARLEN_SINGLE;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arvalid <= 1'b0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
      out_cnt <= 2'd0;
      bus_err <= 1'b0;
    end else begin
      // A new accept can only happen with arvalid low, so it never overlaps a pending AR.
      if (accept) begin
        arvalid <= 1'b1;
        araddr  <= inst_sram_addr;
        arsize  <= {1'b0, inst_sram_size};
      end else if (arready) begin
        arvalid <= 1'b0;
      end

      if (accept && !r_fire) begin
        out_cnt <= out_cnt + 2'd1;
      end else if (!accept && r_fire) begin
        out_cnt <= out_cnt - 2'd1;
      end

      if (r_fire && (rresp != RESP_OKAY)) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed vector table plus randomized traffic checked against a queue-based read model.
module tb_inst_axi_bridge;
  import inst_axi_bridge_pkg::*;

  localparam int         MAX_OUT = 2;
  localparam logic [3:0] AXI_ID  = 4'd0;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        bus_err;

  inst_axi_bridge #(.AXI_ID(AXI_ID), .MAX_OUT(MAX_OUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        chk;
    logic        e_addr_ok;
    logic        e_data_ok;
    logic        e_arvalid;
    logic        e_rready;
    logic        e_bus_err;
    logic [31:0] e_araddr;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: pending AR slot plus a queue of accepted-but-unreturned addresses.
  bit          model_valid = 1'b0;
  bit          m_ar_busy;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  bit          m_err;
  logic [31:0] m_inflight[$];

  function automatic bit modelAccept();
    return (aresetn === 1'b1) && (inst_sram_req === 1'b1) && (inst_sram_wr === 1'b0) &&
           !m_ar_busy && (m_inflight.size() < MAX_OUT);
  endfunction

  function automatic bit modelReturn();
    return (rvalid === 1'b1) && (m_inflight.size() != 0);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addRow(input logic rst_n, input logic req, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic arr, input logic rv,
                        input logic [31:0] rd, input logic [1:0] rr, input logic chk,
                        input logic ok, input logic dok, input logic arv, input logic rdy,
                        input logic err, input logic [31:0] earaddr);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.wr = wr; v.size = size; v.addr = addr;
    v.arready = arr; v.rvalid = rv; v.rdata = rd; v.rresp = rr; v.chk = chk;
    v.e_addr_ok = ok; v.e_data_ok = dok; v.e_arvalid = arv; v.e_rready = rdy;
    v.e_bus_err = err; v.e_araddr = earaddr;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    aresetn         = v.rst_n;
    inst_sram_req   = v.req;
    inst_sram_wr    = v.wr;
    inst_sram_size  = v.size;
    inst_sram_addr  = v.addr;
    inst_sram_wstrb = 4'hf;
    inst_sram_wdata = 32'h5a5a5a5a;
    arready         = v.arready;
    rvalid          = v.rvalid;
    rdata           = v.rdata;
    rresp           = v.rresp;
    rid             = 4'd0;
    rlast           = 1'b1;
  endtask

  task automatic checkOutput(input vec_t v);
    if (v.chk) begin
      checkVal("tbl_addr_ok", 32'(inst_sram_addr_ok), 32'(v.e_addr_ok));
      checkVal("tbl_data_ok", 32'(inst_sram_data_ok), 32'(v.e_data_ok));
      checkVal("tbl_arvalid", 32'(arvalid), 32'(v.e_arvalid));
      checkVal("tbl_rready", 32'(rready), 32'(v.e_rready));
      checkVal("tbl_bus_err", 32'(bus_err), 32'(v.e_bus_err));
      if (v.e_arvalid) checkVal("tbl_araddr", araddr, v.e_araddr);
    end
    if (model_valid) begin
      checkVal("addr_ok", 32'(inst_sram_addr_ok), 32'(modelAccept()));
      checkVal("data_ok", 32'(inst_sram_data_ok), 32'(modelReturn()));
      checkVal("rready", 32'(rready), 32'(m_inflight.size() != 0));
      checkVal("arvalid", 32'(arvalid), 32'(m_ar_busy));
      checkVal("araddr", araddr, m_araddr);
      checkVal("arsize", 32'(arsize), 32'(m_arsize));
      checkVal("bus_err", 32'(bus_err), 32'(m_err));
      checkVal("rdata", inst_sram_rdata, rdata);
      checkVal("ar_consts", {9'd0, arid, arlen, arburst, arlock, arcache, arprot},
               {9'd0, AXI_ID, 8'd0, BURST_INCR, 2'd0, 4'd0, 3'd0});
    end
  endtask

  task automatic modelUpdate();
    bit acc;
    bit ret;
    if (aresetn === 1'b0) begin
      m_ar_busy = 1'b0; m_araddr = 32'd0; m_arsize = 3'd0; m_err = 1'b0;
      m_inflight.delete();
      model_valid = 1'b1;
      return;
    end
    acc = modelAccept();
    ret = modelReturn();
    if (ret) begin
      void'(m_inflight.pop_front());
      if (rresp != RESP_OKAY) m_err = 1'b1;
    end
    if (m_ar_busy && arready === 1'b1) m_ar_busy = 1'b0;
    if (acc) begin
      m_ar_busy = 1'b1;
      m_araddr  = inst_sram_addr;
      m_arsize  = {1'b0, inst_sram_size};
      m_inflight.push_back(inst_sram_addr);
    end
  endtask

  task automatic stepCycle(input vec_t v);
    applyStimulus(v);
    #2;
    checkOutput(v);
    @(posedge aclk);
    modelUpdate();
    #1;
  endtask

  initial begin
    vec_t v;
    // rst req wr size addr arready rvalid rdata rresp | chk ok dok arv rdy err araddr
    addRow(0,1,0,SRAM_SIZE_WORD,32'h1fc00000,0,1,32'h0,2'd0, 0,0,0,0,0,0,32'h0);
    addRow(0,1,0,SRAM_SIZE_WORD,32'h1fc00000,0,1,32'h0,2'd0, 1,0,0,0,0,0,32'h0);
    // single read
    addRow(1,1,0,SRAM_SIZE_WORD,32'h1fc00000,0,0,32'h0,2'd0, 1,1,0,0,0,0,32'h0);
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,1,0,32'h0,2'd0, 1,0,0,1,1,0,32'h1fc00000);
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,0,1,32'h3c1a0001,2'd0, 1,0,1,0,1,0,32'h0);
    // AR backpressure
    addRow(1,1,0,SRAM_SIZE_WORD,32'h00001000,0,0,32'h0,2'd0, 1,1,0,0,0,0,32'h0);
    for (int i = 0; i < 5; i++)
      addRow(1,1,0,SRAM_SIZE_WORD,32'h0000dead,0,0,32'h0,2'd0, 1,0,0,1,1,0,32'h00001000);
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,1,0,32'h0,2'd0, 1,0,0,1,1,0,32'h00001000);
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,0,1,32'h11112222,2'd0, 1,0,1,0,1,0,32'h0);
    // outstanding limit with req held high
    addRow(1,1,0,SRAM_SIZE_WORD,32'h100,1,0,32'h0,2'd0, 1,1,0,0,0,0,32'h0);
    addRow(1,1,0,SRAM_SIZE_WORD,32'h104,1,0,32'h0,2'd0, 1,0,0,1,1,0,32'h100);
    addRow(1,1,0,SRAM_SIZE_WORD,32'h104,1,0,32'h0,2'd0, 1,1,0,0,1,0,32'h0);
    addRow(1,1,0,SRAM_SIZE_WORD,32'h108,1,0,32'h0,2'd0, 1,0,0,1,1,0,32'h104);
    addRow(1,1,0,SRAM_SIZE_WORD,32'h108,1,0,32'h0,2'd0, 1,0,0,0,1,0,32'h0);
    addRow(1,1,0,SRAM_SIZE_WORD,32'h108,1,0,32'h0,2'd0, 1,0,0,0,1,0,32'h0);
    addRow(1,1,0,SRAM_SIZE_WORD,32'h108,1,1,32'haaaa0001,2'd0, 1,0,1,0,1,0,32'h0);
    addRow(1,1,0,SRAM_SIZE_WORD,32'h108,1,0,32'h0,2'd0, 1,1,0,0,1,0,32'h0);
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,1,1,32'haaaa0002,2'd0, 1,0,1,1,1,0,32'h108);
    // accept and return in the same cycle
    addRow(1,1,0,SRAM_SIZE_WORD,32'h10c,1,1,32'haaaa0003,2'd0, 1,1,1,0,1,0,32'h0);
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,1,0,32'h0,2'd0, 1,0,0,1,1,0,32'h10c);
    // error response, then stray rvalid with nothing outstanding
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,0,1,32'hbad0bad0,2'b10, 1,0,1,0,1,0,32'h0);
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,0,1,32'h12345678,2'd0, 1,0,0,0,0,1,32'h0);
    // writes are never acknowledged
    for (int i = 0; i < 10; i++)
      addRow(1,1,1,SRAM_SIZE_WORD,32'h2000,1,0,32'h0,2'd0, 1,0,0,0,0,1,32'h0);
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,0,0,32'h0,2'd0, 1,0,0,0,0,1,32'h0);
    addRow(0,1,0,SRAM_SIZE_WORD,32'h0,0,0,32'h0,2'd0, 1,0,0,0,0,1,32'h0);
    addRow(1,0,0,SRAM_SIZE_WORD,32'h0,0,0,32'h0,2'd0, 1,0,0,0,0,0,32'h0);

    foreach (vecs[i]) stepCycle(vecs[i]);
    $display("[TB] directed table applied: %0d rows", vecs.size());

    v = vecs[0];
    v.chk = 1'b0;
    v.rst_n = 1'b0;
    stepCycle(v);
    for (int n = 0; n < 800; n++) begin
      v.rst_n   = ($urandom_range(0, 199) != 0);
      v.req     = ($urandom_range(0, 2) != 0);
      v.wr      = ($urandom_range(0, 15) == 0);
      v.size    = 2'($urandom_range(0, 2));
      v.addr    = $urandom;
      v.arready = 1'($urandom_range(0, 1));
      v.rvalid  = 1'($urandom_range(0, 1));
      v.rdata   = $urandom;
      v.rresp   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
      v.chk     = 1'b0;
      stepCycle(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
